// File: rtl/string_hw_master.sv
// string_hw_master: Avalon-MM initiator driving the string accelerator's register
// slave for a streaming client. Takes a command (index, length) and 2*MAX_BLOCKS
// string words, writes them to the A/B blocks, sets go, polls until done, streams
// MAX_BLOCKS result words back, then clears go.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid/ready, cmd_index/length command handshake and fields
//   in_valid/ready, in_data           string word stream (A words then B words)
//   res_valid/ready, res_data/last    result word stream
//   busy, timeout_err                 status (timeout_err is a one-cycle pulse)
//   avm_*                             Avalon-MM master, read latency 1, no waitrequest
module string_hw_master #(
   parameter int unsigned MAX_BLOCKS   = 2,
   parameter int unsigned ADDRESS_BITS = 4,
   parameter int unsigned POLL_LIMIT   = 1023
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [3:0]              cmd_index,
   input  logic [7:0]              cmd_length,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [31:0]             res_data,
   output logic                    res_last,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [ADDRESS_BITS:0]   avm_address,
   output logic                    avm_chipselect,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [31:0]             avm_writedata,
   input  logic [31:0]             avm_readdata
);

   localparam int unsigned AW = ADDRESS_BITS + 1;
   localparam int unsigned NW = 2 * MAX_BLOCKS;
   localparam int unsigned KW = $clog2(NW + 1);
   localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_GO, S_POLL_RD, S_POLL_WAIT,
      S_RES_RD, S_RES_WAIT, S_RES_OUT, S_CLEAR
   } state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [PW-1:0] poll_cnt;
   logic [3:0]    idx_q;
   logic [7:0]    len_q;

   // Bus strobes are registered so that each state's bus cycle is visible
   // during that state; the decision is made on the edge that enters it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         k              <= '0;
         poll_cnt       <= '0;
         idx_q          <= '0;
         len_q          <= '0;
         cmd_ready      <= 1'b0;
         in_ready       <= 1'b0;
         res_valid      <= 1'b0;
         res_data       <= '0;
         res_last       <= 1'b0;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
      end else begin
         avm_chipselect <= 1'b0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         timeout_err    <= 1'b0;

         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  idx_q     <= cmd_index;
                  len_q     <= cmd_length;
                  k         <= '0;
                  poll_cnt  <= '0;
                  busy      <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= S_LOAD;
               end
            end

            // A words land at 1..MAX_BLOCKS and B words directly after, so the
            // address is simply 1+k for every accepted word.
            S_LOAD: begin
               if (in_ready) begin
                  if (in_valid) begin
                     avm_chipselect <= 1'b1;
                     avm_write      <= 1'b1;
                     avm_address    <= AW'(k) + AW'(1);
                     avm_writedata  <= in_data;
                     k              <= k + KW'(1);
                     if (k == KW'(NW - 1)) in_ready <= 1'b0;
                  end
               end else begin
                  // last data write is on the bus now; the go write follows it
                  avm_chipselect <= 1'b1;
                  avm_write      <= 1'b1;
                  avm_address    <= '0;
                  avm_writedata  <= {18'b0, len_q, idx_q, 1'b1, 1'b0};
                  state          <= S_GO;
               end
            end

            S_GO: begin
               avm_chipselect <= 1'b1;
               avm_read       <= 1'b1;
               avm_address    <= '0;
               poll_cnt       <= poll_cnt + PW'(1);
               state          <= S_POLL_RD;
            end

            S_POLL_RD: state <= S_POLL_WAIT;

            // Done is checked before the limit so a done on the last poll wins.
            S_POLL_WAIT: begin
               if (avm_readdata[0]) begin
                  k              <= '0;
                  avm_chipselect <= 1'b1;
                  avm_read       <= 1'b1;
                  avm_address    <= AW'(1);
                  state          <= S_RES_RD;
               end else if (poll_cnt == PW'(POLL_LIMIT)) begin
                  timeout_err    <= 1'b1;
                  avm_chipselect <= 1'b1;
                  avm_write      <= 1'b1;
                  avm_address    <= '0;
                  avm_writedata  <= '0;
                  state          <= S_CLEAR;
               end else begin
                  avm_chipselect <= 1'b1;
                  avm_read       <= 1'b1;
                  avm_address    <= '0;
                  poll_cnt       <= poll_cnt + PW'(1);
                  state          <= S_POLL_RD;
               end
            end

            S_RES_RD: state <= S_RES_WAIT;

            S_RES_WAIT: begin
               res_data  <= avm_readdata;
               res_valid <= 1'b1;
               res_last  <= (k == KW'(MAX_BLOCKS - 1));
               state     <= S_RES_OUT;
            end

            S_RES_OUT: begin
               if (res_ready) begin
                  res_valid      <= 1'b0;
                  res_last       <= 1'b0;
                  avm_chipselect <= 1'b1;
                  if (k == KW'(MAX_BLOCKS - 1)) begin
                     avm_write     <= 1'b1;
                     avm_address   <= '0;
                     avm_writedata <= '0;
                     state         <= S_CLEAR;
                  end else begin
                     avm_read    <= 1'b1;
                     avm_address <= AW'(k) + AW'(2);
                     k           <= k + KW'(1);
                     state       <= S_RES_RD;
                  end
               end
            end

            S_CLEAR: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_string_hw_master.sv
// Self-checking bench for string_hw_master: slave register model, bus and result
// monitors, and a transaction-level reference of the expected bus traffic.
module tb_string_hw_master;

   localparam int MB = 2;
   localparam int NW = 2 * MB;
   localparam int PL = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_index;
   logic [7:0]  cmd_length;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic        res_valid, res_ready, res_last;
   logic [31:0] res_data;
   logic        busy, timeout_err;
   logic [4:0]  avm_address;
   logic        avm_chipselect, avm_read, avm_write;
   logic [31:0] avm_writedata, avm_readdata;

   string_hw_master #(.MAX_BLOCKS(MB), .ADDRESS_BITS(4), .POLL_LIMIT(PL)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_length(cmd_length),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_last(res_last),
      .busy(busy), .timeout_err(timeout_err),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // transaction context shared with the slave model and monitors
   logic [31:0] w_arr [NW];
   logic [31:0] r_arr [MB];
   int          done_after = 0;
   int          polls      = 0;
   int          cyc        = 0;
   int          rr_mode    = 0;
   int          hold_cnt   = 0;
   int          to_cnt     = 0;
   int          stall_seen = 0;
   int          rv_cnt     = 0;
   logic [37:0] bus_q [$];
   int          cyc_q [$];
   logic [32:0] res_q [$];
   bit          prev_stall = 1'b0;
   logic [32:0] prev_res   = '0;

   always @(posedge clk) cyc++;

   // accelerator register slave: read data valid the cycle after the read
   always @(posedge clk) begin
      if (avm_read && avm_chipselect) begin
         if (avm_address == 5'd0) begin
            polls = polls + 1;
            avm_readdata <= {31'h0, (done_after != 0 && polls >= done_after)};
         end else if (int'(avm_address) >= 1 && int'(avm_address) <= MB)
            avm_readdata <= r_arr[int'(avm_address) - 1];
         else
            avm_readdata <= 32'hDEAD_BEEF;
      end else begin
         avm_readdata <= 32'hFFFF_FFFF;   // garbage, done bit set, outside the data cycle
      end
   end

   // result consumer
   always begin
      @(posedge clk); #1;
      case (rr_mode)
         1: res_ready = 1'($urandom_range(0, 1));
         2: begin
            if (res_valid && hold_cnt <= 10) hold_cnt++;
            res_ready = (hold_cnt > 10);
         end
         default: res_ready = 1'b1;
      endcase
   end

   // bus / result monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (reset_n) begin
         chk("cs_eq_strobe", 64'(avm_chipselect), 64'(avm_read | avm_write));
         chk("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
         if (avm_read || avm_write) begin
            bus_q.push_back({avm_write, avm_address, avm_write ? avm_writedata : 32'h0});
            cyc_q.push_back(cyc);
         end
         if (res_valid) rv_cnt++;
         if (res_valid && res_ready) res_q.push_back({res_last, res_data});
         if (timeout_err) to_cnt++;
         if (prev_stall) begin
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data", 64'({res_last, res_data}), 64'(prev_res));
         end
         if (res_valid && !res_ready) begin
            stall_seen++;
            chk("stall_bus", 64'(avm_read | avm_write), 64'd0);
         end
         prev_stall = res_valid && !res_ready;
         prev_res   = {res_last, res_data};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send_cmd(input logic [3:0] idx, input logic [7:0] len);
      bit hs = 1'b0;
      int b  = 0;
      cmd_index = idx; cmd_length = len; cmd_valid = 1'b1;
      while (!hs && b < 50) begin
         @(negedge clk); hs = cmd_ready;
         @(posedge clk); #1; b++;
      end
      cmd_valid = 1'b0;
      if (!hs) chk("cmd_hs_timeout", 64'd0, 64'd1);
      else     chk("busy_after_cmd", 64'(busy), 64'd1);
   endtask

   // streams n words; a conflicting command is offered meanwhile and must be ignored
   task automatic stream(input int n, input bit gaps, input logic [3:0] junk_idx);
      int i = 0;
      int b = 0;
      bit acc;
      cmd_valid = 1'b1; cmd_index = junk_idx;
      while (i < n && b < 500) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0; in_data = $urandom;
         end else begin
            in_valid = 1'b1; in_data = w_arr[i];
         end
         @(negedge clk); acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         b++;
      end
      in_valid = 1'b0; cmd_valid = 1'b0;
      if (i < n) chk("stream_timeout", 64'(i), 64'(n));
   endtask

   task automatic wait_idle();
      int b = 0;
      while (busy && b < 2000) begin
         @(negedge clk); b++;
      end
      if (busy) chk("idle_timeout", 64'd0, 64'd1);
      else      chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
   endtask

   task automatic run_txn(input logic [3:0] idx, input logic [7:0] len, input int da,
                          input int rr, input bit gaps, input bit directed);
      logic [37:0] e_bus [$];
      logic [32:0] e_res [$];
      bit ok;
      int np;
      bus_q.delete(); cyc_q.delete(); res_q.delete();
      to_cnt = 0; stall_seen = 0; rv_cnt = 0; polls = 0; hold_cnt = 0;
      done_after = da; rr_mode = rr;
      // words offered while idle must not be taken
      in_valid = 1'b1; in_data = $urandom;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      send_cmd(idx, len);
      stream(NW, gaps, ~idx);
      wait_idle();

      // expected traffic from the transaction description
      ok = (da != 0) && (da <= PL);
      np = ok ? da : PL;
      for (int i = 0; i < NW; i++) e_bus.push_back({1'b1, 5'(i + 1), w_arr[i]});
      e_bus.push_back({1'b1, 5'd0, 32'((int'(len) << 6) + (int'(idx) << 2) + 2)});
      for (int i = 0; i < np; i++) e_bus.push_back({1'b0, 5'd0, 32'h0});
      if (ok) begin
         for (int i = 0; i < MB; i++) begin
            e_bus.push_back({1'b0, 5'(i + 1), 32'h0});
            e_res.push_back({(i == MB - 1), r_arr[i]});
         end
      end
      e_bus.push_back({1'b1, 5'd0, 32'h0});

      chk("bus_count", 64'(bus_q.size()), 64'(e_bus.size()));
      for (int i = 0; i < e_bus.size() && i < bus_q.size(); i++)
         chk($sformatf("bus_%0d", i), 64'(bus_q[i]), 64'(e_bus[i]));
      chk("res_count", 64'(res_q.size()), 64'(e_res.size()));
      for (int i = 0; i < e_res.size() && i < res_q.size(); i++)
         chk($sformatf("res_%0d", i), 64'(res_q[i]), 64'(e_res[i]));
      chk("timeout_pulses", 64'(to_cnt), ok ? 64'd0 : 64'd1);
      if (!ok) chk("no_res_valid", 64'(rv_cnt), 64'd0);
      if (directed && cyc_q.size() > NW)
         for (int i = 0; i < NW; i++)
            chk($sformatf("b2b_%0d", i), 64'(cyc_q[i + 1] - cyc_q[i]), 64'd1);
      if (rr == 2) chk("stall_cycles", 64'(stall_seen >= 10), 64'd1);
      rr_mode = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b1; cmd_index = 4'h3; cmd_length = 8'd5;
      in_valid = 1'b0; in_data = '0; res_ready = 1'b1;

      // reset state with a command already pending
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 64'({cmd_ready, in_ready, res_valid, res_last, busy, timeout_err}), 64'd0);
      chk("rst_data", 64'(res_data), 64'd0);
      chk("rst_bus", 64'({avm_address, avm_chipselect, avm_read, avm_write, avm_writedata}), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rdy_after_rst", 64'(cmd_ready), 64'd1);
      chk("idle_quiet", 64'({busy, avm_chipselect, avm_read, avm_write}), 64'd0);
      cmd_valid = 1'b0;
      @(posedge clk); #1;

      // directed: index 3, length 5, done on third poll
      w_arr = '{32'h61626364, 32'h65666700, 32'h61626364, 32'h65666700};
      r_arr = '{32'h0000_0001, 32'h0000_0000};
      run_txn(4'h3, 8'd5, 3, 0, 1'b0, 1'b1);

      // consumer stalls the first result for 10 cycles
      run_txn(4'h3, 8'd5, 1, 2, 1'b0, 1'b0);

      // done never set: timeout after POLL_LIMIT polls
      run_txn(4'h7, 8'd9, 0, 0, 1'b0, 1'b0);

      // reset mid-LOAD after two words
      send_cmd(4'h9, 8'd7);
      stream(2, 1'b0, 4'h0);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_strobes", 64'({avm_chipselect, avm_read, avm_write}), 64'd0);
      chk("midrst_ready", 64'({in_ready, cmd_ready}), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      r_arr = '{32'hCAFE_0001, 32'h1234_5678};
      run_txn(4'h9, 8'd7, 2, 0, 1'b0, 1'b1);

      // randomized transactions
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < NW; i++) w_arr[i] = $urandom;
         for (int i = 0; i < MB; i++) r_arr[i] = $urandom;
         run_txn(4'($urandom), 8'($urandom), int'($urandom_range(0, PL + 1)), 1, 1'b1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
